// File: rtl/dna_search_loader_pkg.sv
// dna_pkg: nucleotide bp codes, loader state encoding and ASCII-to-bp helper.
package dna_pkg;

    localparam logic [3:0] BP_A = 4'b1000;
    localparam logic [3:0] BP_C = 4'b0100;
    localparam logic [3:0] BP_G = 4'b0010;
    localparam logic [3:0] BP_T = 4'b0001;
    localparam logic [3:0] BP_R = 4'b1010;
    localparam logic [3:0] BP_Y = 4'b0101;
    localparam logic [3:0] BP_N = 4'b1111;

    typedef enum logic [5:0] {
        ST_LOAD      = 6'b000001,
        ST_DRAIN     = 6'b000010,
        ST_LAUNCH    = 6'b000100,
        ST_WAIT_DONE = 6'b001000,
        ST_RESULT    = 6'b010000,
        ST_RECOVER   = 6'b100000
    } state_e;

    // Returns {valid, code}; unknown characters give {0, 4'b0000}.
    function automatic logic [4:0] ascii_to_bp(input logic [7:0] ch);
        logic [4:0] r;
        case (ch)
            8'h41, 8'h61: r = {1'b1, BP_A};
            8'h43, 8'h63: r = {1'b1, BP_C};
            8'h47, 8'h67: r = {1'b1, BP_G};
            8'h54, 8'h74: r = {1'b1, BP_T};
            8'h52, 8'h72: r = {1'b1, BP_R};
            8'h59, 8'h79: r = {1'b1, BP_Y};
            8'h4E, 8'h6E: r = {1'b1, BP_N};
            default:      r = 5'b0_0000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dna_search_loader_if.sv
// dna_search_loader_if: character stream into the loader and result handshake out of it.
// master = upstream producer / result consumer, slave = the loader.
interface dna_search_loader_if #(
    parameter int OLN = 5
) ();
    logic           s_valid;
    logic           s_ready;
    logic [7:0]     s_data;
    logic           s_last;
    logic           res_valid;
    logic           res_ready;
    logic           res_found;
    logic [OLN-1:0] res_location;
    logic           res_error;

    modport master (
        output s_valid, s_data, s_last, res_ready,
        input  s_ready, res_valid, res_found, res_location, res_error
    );

    modport slave (
        input  s_valid, s_data, s_last, res_ready,
        output s_ready, res_valid, res_found, res_location, res_error
    );
endinterface

// File: rtl/dna_search_loader_encoder.sv
// dna_ascii_encoder: combinational ASCII nucleotide to one-hot bp code with validity flag.
module dna_ascii_encoder
    import dna_pkg::*;
(
    input  logic [7:0] ch,
    output logic       valid,
    output logic [3:0] bp
);

    // Case-insensitive lookup; invalid characters encode as 0000.
    always_comb begin
        {valid, bp} = ascii_to_bp(ch);
    end

endmodule

// File: rtl/dna_search_loader.sv
// dna_search_loader: packs an ASCII record into query/target bp vectors, launches one
// search, returns the result on a handshake and re-arms the searcher.
// Optional build macro DNA_SEARCH_TIMEOUT_EN adds a watchdog on the searcher DONE wait.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// LOAD      | accepting chars, shifting codes into smallSeq then bigSeq
// DRAIN     | record overran its length; discard chars up to s_last
// LAUNCH    | one cycle: pulse srch_START, or skip search on error
// WAIT_DONE | waiting for searcher DONE (or watchdog expiry)
// RESULT    | res_valid high, fields held until res_ready
// RECOVER   | one cycle: searcher held in reset, datapath cleared
module dna_search_loader
    import dna_pkg::*;
#(
    parameter int BIG_SEQ_SIZE            = 32,
    parameter int SMALL_SEQ_SIZE          = 8,
    parameter int OUTER_LOCATION_NUM_SIZE = 5,
    parameter int TIMEOUT_CYCLES          = 1024
) (
    input  logic                               CLK,
    input  logic                               RST,
    dna_search_loader_if.slave                 bus,
    output logic [BIG_SEQ_SIZE-1:0]            bigSeq,
    output logic [SMALL_SEQ_SIZE-1:0]          smallSeq,
    output logic [OUTER_LOCATION_NUM_SIZE-1:0] startIndex,
    output logic                               srch_START,
    output logic                               srch_RST,
    input  logic                               srch_DONE,
    input  logic                               srch_found,
    input  logic [OUTER_LOCATION_NUM_SIZE-1:0] srch_location
);

    localparam int BIG_BP   = BIG_SEQ_SIZE / 4;
    localparam int SMALL_BP = SMALL_SEQ_SIZE / 4;
    localparam int TOTAL_BP = SMALL_BP + BIG_BP;
    localparam int CNT_W    = $clog2(TOTAL_BP + 1);
    localparam int OLN      = OUTER_LOCATION_NUM_SIZE;

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      err_q, err_d;
    logic [SMALL_SEQ_SIZE-1:0] small_q, small_d;
    logic [BIG_SEQ_SIZE-1:0]   big_q, big_d;
    logic                      s_ready_q, s_ready_d;
    logic                      srch_rst_q, srch_rst_d;
    logic                      res_found_q, res_found_d;
    logic [OLN-1:0]            res_location_q, res_location_d;
    logic                      res_error_q, res_error_d;

    logic                      enc_valid;
    logic [3:0]                enc_bp;
    logic                      accept;
    logic [CNT_W-1:0]          cnt_inc;
    logic                      last_slot;
    logic                      wdog_expired;

    dna_ascii_encoder u_enc (
        .ch    (bus.s_data),
        .valid (enc_valid),
        .bp    (enc_bp)
    );

    assign accept    = bus.s_valid && s_ready_q;
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign last_slot = (cnt_inc == CNT_W'(TOTAL_BP));

`ifdef DNA_SEARCH_TIMEOUT_EN
    // Down-counter reloaded outside a search; it starts decrementing in the launch cycle
    // so the error result appears TIMEOUT_CYCLES cycles after the START pulse.
    localparam logic [15:0] WDOG_LOAD = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wdog_q, wdog_d;

    // Watchdog next value.
    always_comb begin
        wdog_d = WDOG_LOAD;
        if (state_q == ST_LAUNCH || state_q == ST_WAIT_DONE) begin
            wdog_d = wdog_q - 16'd1;
        end
    end

    // Watchdog register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wdog_q <= WDOG_LOAD;
        end else begin
            wdog_q <= wdog_d;
        end
    end

    assign wdog_expired = (state_q == ST_WAIT_DONE) && (wdog_q == 16'd0);
`else
    logic [15:0] unused_timeout;
    assign unused_timeout = 16'(TIMEOUT_CYCLES);
    assign wdog_expired   = 1'b0;
`endif

    // State and datapath registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q        <= ST_LOAD;
            cnt_q          <= '0;
            err_q          <= 1'b0;
            small_q        <= '0;
            big_q          <= '0;
            s_ready_q      <= 1'b0;
            srch_rst_q     <= 1'b0;
            res_found_q    <= 1'b0;
            res_location_q <= '0;
            res_error_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            err_q          <= err_d;
            small_q        <= small_d;
            big_q          <= big_d;
            s_ready_q      <= s_ready_d;
            srch_rst_q     <= srch_rst_d;
            res_found_q    <= res_found_d;
            res_location_q <= res_location_d;
            res_error_q    <= res_error_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD: begin
                if (accept) begin
                    if (bus.s_last) begin
                        state_d = ST_LAUNCH;
                    end else if (last_slot) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (accept && bus.s_last) begin
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH:    state_d = err_q ? ST_RESULT : ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (srch_DONE || wdog_expired) begin
                    state_d = ST_RESULT;
                end
            end
            ST_RESULT: begin
                if (bus.res_ready) begin
                    state_d = ST_RECOVER;
                end
            end
            ST_RECOVER:   state_d = ST_LOAD;
            default:      state_d = ST_LOAD;
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin
        cnt_d          = cnt_q;
        err_d          = err_q;
        small_d        = small_q;
        big_d          = big_q;
        res_found_d    = res_found_q;
        res_location_d = res_location_q;
        res_error_d    = res_error_q;
        s_ready_d      = (state_d == ST_LOAD) || (state_d == ST_DRAIN);
        srch_rst_d     = (state_d != ST_RECOVER);

        case (state_q)
            ST_LOAD: begin
                if (accept) begin
                    if (cnt_q < CNT_W'(SMALL_BP)) begin
                        small_d = {small_q[SMALL_SEQ_SIZE-5:0], enc_bp};
                    end else begin
                        big_d = {big_q[BIG_SEQ_SIZE-5:0], enc_bp};
                    end
                    cnt_d = cnt_inc;
                    // Bad char, early s_last, or a full record missing s_last.
                    if (!enc_valid || (bus.s_last != last_slot)) begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_LAUNCH: begin
                if (err_q) begin
                    res_found_d    = 1'b0;
                    res_location_d = '0;
                    res_error_d    = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (srch_DONE) begin
                    res_found_d    = srch_found;
                    res_location_d = srch_location;
                    res_error_d    = 1'b0;
                end else if (wdog_expired) begin
                    res_found_d    = 1'b0;
                    res_location_d = '0;
                    res_error_d    = 1'b1;
                end
            end
            ST_RECOVER: begin
                cnt_d   = '0;
                err_d   = 1'b0;
                small_d = '0;
                big_d   = '0;
            end
            default: ;
        endcase
    end

    // Combinational outputs; RST also drops srch_RST immediately to abort the searcher.
    always_comb begin
        srch_START       = (state_q == ST_LAUNCH) && !err_q;
        srch_RST         = srch_rst_q && !RST;
        bus.s_ready      = s_ready_q;
        bus.res_valid    = (state_q == ST_RESULT);
        bus.res_found    = res_found_q;
        bus.res_location = res_location_q;
        bus.res_error    = res_error_q;
        bigSeq           = big_q;
        smallSeq         = small_q;
        startIndex       = OLN'(BIG_SEQ_SIZE - 1);
    end

endmodule

// File: tb/tb_dna_search_loader.sv
// tb_dna_search_loader: directed checks of dna_search_loader against a searcher stub
// with programmable DONE latency, found flag and location.
module tb_dna_search_loader;

    localparam int BIG   = 32;
    localparam int SMALL = 8;
    localparam int OLN   = 5;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic [BIG-1:0]  bigSeq;
    logic [SMALL-1:0] smallSeq;
    logic [OLN-1:0]  startIndex;
    logic            srch_START;
    logic            srch_RST;
    logic            srch_DONE = 1'b0;
    logic            srch_found = 1'b0;
    logic [OLN-1:0]  srch_location = '0;

    int  stub_lat  = 7;
    bit  stub_hang = 1'b0;
    int  stub_cnt  = 0;
    bit  stub_busy = 1'b0;

    int  start_cnt   = 0;
    int  rst_low_cnt = 0;
    int  n_checks    = 0;
    int  n_pass      = 0;

    dna_search_loader_if #(.OLN(OLN)) bus ();

    dna_search_loader #(
        .BIG_SEQ_SIZE            (BIG),
        .SMALL_SEQ_SIZE          (SMALL),
        .OUTER_LOCATION_NUM_SIZE (OLN),
        .TIMEOUT_CYCLES          (16)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .bus           (bus),
        .bigSeq        (bigSeq),
        .smallSeq      (smallSeq),
        .startIndex    (startIndex),
        .srch_START    (srch_START),
        .srch_RST      (srch_RST),
        .srch_DONE     (srch_DONE),
        .srch_found    (srch_found),
        .srch_location (srch_location)
    );

    always #5 CLK = ~CLK;

    // Searcher stub: DONE rises stub_lat cycles after START, held until srch_RST low.
    always @(posedge CLK) begin
        if (!srch_RST) begin
            stub_busy <= 1'b0;
            srch_DONE <= 1'b0;
        end else if (srch_START) begin
            stub_busy <= 1'b1;
            stub_cnt  <= stub_lat;
        end else if (stub_busy && !srch_DONE && !stub_hang) begin
            if (stub_cnt <= 1) srch_DONE <= 1'b1;
            stub_cnt <= stub_cnt - 1;
        end
    end

    always @(negedge CLK) begin
        if (srch_START === 1'b1) start_cnt++;
        if (srch_RST === 1'b0) rst_low_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=no_finish required=finish");
        $fatal(1, "bench time limit");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed='h%0h required='h%0h", tag, obs, exp);
        end
    endtask

    task automatic send_char(input logic [7:0] ch, input logic last);
        int guard;
        guard = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = ch;
        bus.s_last  = last;
        while (bus.s_ready !== 1'b1 && guard < 100) begin
            @(negedge CLK);
            guard++;
        end
        if (guard >= 100) chk("send_accept_timeout", bus.s_ready, 1'b1);
        @(negedge CLK);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic send_str(input string s, input bit last_on_end);
        for (int i = 0; i < s.len(); i++) begin
            send_char(s[i], last_on_end && (i == s.len() - 1));
        end
    endtask

    task automatic wait_result(input string tag);
        int i;
        i = 0;
        while (bus.res_valid !== 1'b1 && i < 200) begin
            @(negedge CLK);
            i++;
        end
        chk({tag, "_res_valid"}, bus.res_valid, 1'b1);
    endtask

    task automatic check_result(input string tag, input logic f, input logic [OLN-1:0] loc, input logic e);
        chk({tag, "_found"}, bus.res_found, f);
        chk({tag, "_location"}, bus.res_location, loc);
        chk({tag, "_error"}, bus.res_error, e);
        chk({tag, "_s_ready_res"}, bus.s_ready, 1'b0);
    endtask

    task automatic drain_result(input string tag);
        int rc;
        rc = rst_low_cnt;
        bus.res_ready = 1'b1;
        @(negedge CLK);
        bus.res_ready = 1'b0;
        chk({tag, "_rv_drop"}, bus.res_valid, 1'b0);
        chk({tag, "_srst_low"}, srch_RST, 1'b0);
        chk({tag, "_rdy_recover"}, bus.s_ready, 1'b0);
        @(negedge CLK);
        chk({tag, "_rdy_load"}, bus.s_ready, 1'b1);
        chk({tag, "_srst_high"}, srch_RST, 1'b1);
        chk({tag, "_seq_clear"}, {bigSeq, smallSeq}, 40'h0);
        repeat (2) @(negedge CLK);
        chk({tag, "_srst_pulse_len"}, rst_low_cnt - rc, 1);
    endtask

    initial begin
        int  s0;
        int  n;
        bit  stable;

        bus.s_valid   = 1'b0;
        bus.s_data    = 8'h00;
        bus.s_last    = 1'b0;
        bus.res_ready = 1'b0;

        // Reset values
        repeat (3) @(negedge CLK);
        chk("rst_s_ready", bus.s_ready, 1'b0);
        chk("rst_res_valid", bus.res_valid, 1'b0);
        chk("rst_res_found", bus.res_found, 1'b0);
        chk("rst_res_location", bus.res_location, 5'd0);
        chk("rst_res_error", bus.res_error, 1'b0);
        chk("rst_srch_start", srch_START, 1'b0);
        chk("rst_srch_rst", srch_RST, 1'b0);
        chk("rst_seqs", {bigSeq, smallSeq}, 40'h0);
        chk("start_index", startIndex, 5'd31);
        RST = 1'b0;

        // 1: good record, found at 5
        stub_lat = 7; srch_found = 1'b1; srch_location = 5'd5;
        s0 = start_cnt;
        send_str("ACGGACTTTT", 1'b1);
        chk("t1_small", smallSeq, 8'h84);
        chk("t1_big", bigSeq, 32'h22841111);
        chk("t1_start_pulse", srch_START, 1'b1);
        wait_result("t1");
        check_result("t1", 1'b1, 5'd5, 1'b0);
        chk("t1_start_count", start_cnt - s0, 1);
        chk("t1_big_hold", bigSeq, 32'h22841111);
        drain_result("t1");

        // 2: invalid char
        s0 = start_cnt;
        send_str("AXACGTACGT", 1'b1);
        chk("t2_small", smallSeq, 8'h80);
        chk("t2_big", bigSeq, 32'h84218421);
        chk("t2_no_start_now", srch_START, 1'b0);
        wait_result("t2");
        check_result("t2", 1'b0, 5'd0, 1'b1);
        chk("t2_start_count", start_cnt - s0, 0);
        drain_result("t2");

        // 3a: early s_last
        s0 = start_cnt;
        send_str("ACGT", 1'b1);
        chk("t3a_small", smallSeq, 8'h84);
        chk("t3a_big", bigSeq, 32'h00000021);
        wait_result("t3a");
        check_result("t3a", 1'b0, 5'd0, 1'b1);
        chk("t3a_start_count", start_cnt - s0, 0);
        drain_result("t3a");

        // 3b: overlong record, 11th char discarded in DRAIN
        s0 = start_cnt;
        send_str("ACGTACGTAC", 1'b0);
        chk("t3b_drain_ready", bus.s_ready, 1'b1);
        chk("t3b_no_result_yet", bus.res_valid, 1'b0);
        send_char("G", 1'b1);
        chk("t3b_big_unchanged", bigSeq, 32'h21842184);
        wait_result("t3b");
        check_result("t3b", 1'b0, 5'd0, 1'b1);
        chk("t3b_start_count", start_cnt - s0, 0);
        drain_result("t3b");

        // 4: result held under backpressure, then 2-cycle gap
        stub_lat = 3; srch_found = 1'b0; srch_location = 5'd17;
        send_str("TTRYNacgta", 1'b1);
        chk("t4_small", smallSeq, 8'h11);
        chk("t4_big", bigSeq, 32'hA5F84218);
        wait_result("t4");
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (bus.res_valid !== 1'b1 || bus.res_found !== 1'b0 || bus.res_location !== 5'd17 ||
                bus.res_error !== 1'b0 || bus.s_ready !== 1'b0 || bigSeq !== 32'hA5F84218)
                stable = 1'b0;
        end
        chk("t4_hold_stable", stable, 1'b1);
        check_result("t4", 1'b0, 5'd17, 1'b0);
        bus.res_ready = 1'b1;
        @(negedge CLK);
        bus.res_ready = 1'b0;
        chk("t4_gap_not_ready", bus.s_ready, 1'b0);
        @(negedge CLK);
        chk("t4_gap_ready", bus.s_ready, 1'b1);

        // 5: reset in WAIT_DONE
        stub_lat = 50; srch_found = 1'b1; srch_location = 5'd9;
        send_str("CCAAAAAAAA", 1'b1);
        repeat (3) @(negedge CLK);
        chk("t5_waiting", bus.res_valid, 1'b0);
        chk("t5_srst_running", srch_RST, 1'b1);
        chk("t5_old_location", bus.res_location, 5'd17);
        RST = 1'b1;
        #1;
        chk("t5_srst_same_cycle", srch_RST, 1'b0);
        @(negedge CLK);
        chk("t5_s_ready", bus.s_ready, 1'b0);
        chk("t5_res_valid", bus.res_valid, 1'b0);
        chk("t5_res_location", bus.res_location, 5'd0);
        chk("t5_res_fe", {bus.res_found, bus.res_error}, 2'b00);
        chk("t5_srch", {srch_START, srch_RST}, 2'b00);
        chk("t5_seqs", {bigSeq, smallSeq}, 40'h0);
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        chk("t5_ready_after", bus.s_ready, 1'b1);

        // 6: searcher never finishes
        stub_hang = 1'b1;
        send_str("GATTACAGAT", 1'b1);
        chk("t6_start_pulse", srch_START, 1'b1);
`ifdef DNA_SEARCH_TIMEOUT_EN
        n = 0;
        while (bus.res_valid !== 1'b1 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        chk("t6_timeout_cycles", n, 16);
        check_result("t6", 1'b0, 5'd0, 1'b1);
        drain_result("t6");
`else
        n = 0;
        repeat (2000) @(negedge CLK);
        chk("t6_still_waiting", bus.res_valid, 1'b0);
        chk("t6_no_ready", bus.s_ready, 1'b0);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
`endif
        stub_hang = 1'b0;
        repeat (2) @(negedge CLK);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
